gtxe2_chnl_cpll_lockdet: RTL and testbench



---
 rtl/gtxe2_chnl_cpll_lockdet_if.sv | 35 +++
 rtl/gtxe2_chnl_cpll_lockdet.sv | 196 +++++++++++++++++++
 tb/tb_gtxe2_chnl_cpll_lockdet.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gtxe2_chnl_cpll_lockdet_if.sv
// ----------------------------------------------------------------------------
// gtxe2_chnl_cpll_lockdet_if
//
// Bundle of the CPLL lock-detector channel signals.
//   master : the channel side; drives lock_en, pd and the two observed
//            clocks, and receives the lock/loss status and window counts.
//   slave  : the detector side.
// CNT_W must match the CNT_W of the detector instance bound to it.
// ----------------------------------------------------------------------------
interface gtxe2_chnl_cpll_lockdet_if #(
    parameter int unsigned CNT_W = 16
);
    logic             lock_en;         // CPLLLOCKEN
    logic             pd;              // CPLLPD
    logic             ref_clk;         // CPLL reference clock (async)
    logic             fb_clk;          // CPLL feedback clock (async)
    logic             CPLLLOCK;
    logic             CPLLREFCLKLOST;
    logic             CPLLFBCLKLOST;
    logic [CNT_W-1:0] ref_count;       // ref_clk edges in last window
    logic [CNT_W-1:0] fb_count;        // fb_clk edges in last window
    logic             window_done;     // one-cycle result-update pulse

    modport master (
        output lock_en, pd, ref_clk, fb_clk,
        input  CPLLLOCK, CPLLREFCLKLOST, CPLLFBCLKLOST,
               ref_count, fb_count, window_done
    );

    modport slave (
        input  lock_en, pd, ref_clk, fb_clk,
        output CPLLLOCK, CPLLREFCLKLOST, CPLLFBCLKLOST,
               ref_count, fb_count, window_done
    );
endinterface

// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// ----------------------------------------------------------------------------
// gtxe2_chnl_cpll_lockdet
//
// Frequency-based CPLL lock and clock-loss detector. Counts rising edges of
// ref_clk and fb_clk over a fixed window of lockdet_clk cycles and derives
// CPLLLOCK / CPLLREFCLKLOST / CPLLFBCLKLOST from the counts.
//
// Ports:
//   lockdet_clk : detector clock
//   rst_n       : asynchronous active-low reset
//   bus         : slave side of gtxe2_chnl_cpll_lockdet_if
//                 (lock_en, pd, ref_clk, fb_clk in; status and counts out)
// ----------------------------------------------------------------------------
module gtxe2_chnl_cpll_lockdet #(
    parameter int unsigned WINDOW       = 1024,
    parameter int unsigned REF_EXP      = 256,
    parameter int unsigned FB_EXP       = 1280,
    parameter int unsigned TOL          = 2,
    parameter int unsigned LOCK_WINDOWS = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                            lockdet_clk,
    input  logic                            rst_n,
    gtxe2_chnl_cpll_lockdet_if.slave        bus
);

    localparam int unsigned    WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0] fb_cnt_q, fb_cnt_d;
    logic [3:0]       good_q, good_d;
    logic             lock_q, lock_d;
    logic             ref_lost_q, ref_lost_d;
    logic             fb_lost_q, fb_lost_d;
    logic [CNT_W-1:0] ref_count_q, ref_count_d;
    logic [CNT_W-1:0] fb_count_q, fb_count_d;
    logic             done_q, done_d;
    // [0],[1] are the synchronizer stages, [2] is the edge-detect delay.
    logic [2:0]       ref_sync_q, ref_sync_d;
    logic [2:0]       fb_sync_q, fb_sync_d;

    logic             ref_edge, fb_edge;
    logic [CNT_W-1:0] ref_inc, fb_inc;
    logic             ref_ok, fb_ok;
    logic [3:0]       good_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             hit);
        if (hit && (cnt != '1)) return cnt + CNT_W'(1);
        return cnt;
    endfunction

    // Compared at 32 bits so that neither operand truncates and the
    // subtraction is always taken in the non-negative direction.
    function automatic logic in_tol(input logic [CNT_W-1:0] cnt,
                                    input int unsigned      exp_cnt);
        logic [31:0] c;
        c = 32'(cnt);
        if (c >= exp_cnt) return (c - exp_cnt) <= TOL;
        return (exp_cnt - c) <= TOL;
    endfunction

    assign ref_edge = ref_sync_q[1] & ~ref_sync_q[2];
    assign fb_edge  = fb_sync_q[1]  & ~fb_sync_q[2];
    // The window's last cycle still includes an edge detected in that cycle.
    assign ref_inc  = sat_inc(ref_cnt_q, ref_edge);
    assign fb_inc   = sat_inc(fb_cnt_q, fb_edge);
    assign ref_ok   = in_tol(ref_inc, REF_EXP);
    assign fb_ok    = in_tol(fb_inc, FB_EXP);
    assign good_inc = good_q + 4'd1;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        win_d       = win_q;
        ref_cnt_d   = ref_cnt_q;
        fb_cnt_d    = fb_cnt_q;
        good_d      = good_q;
        lock_d      = lock_q;
        ref_lost_d  = ref_lost_q;
        fb_lost_d   = fb_lost_q;
        ref_count_d = ref_count_q;
        fb_count_d  = fb_count_q;
        done_d      = 1'b0;
        // Synchronizers run in every state so stale levels are flushed
        // before a measurement starts.
        ref_sync_d  = {ref_sync_q[1:0], bus.ref_clk};
        fb_sync_d   = {fb_sync_q[1:0], bus.fb_clk};

        if (bus.pd || !bus.lock_en) begin
            // Disable overrides every state and discards any partial window.
            state_d     = IDLE;
            win_d       = '0;
            ref_cnt_d   = '0;
            fb_cnt_d    = '0;
            good_d      = '0;
            lock_d      = 1'b0;
            ref_lost_d  = 1'b0;
            fb_lost_d   = 1'b0;
            ref_count_d = '0;
            fb_count_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = MEASURE;
                    win_d     = '0;
                    ref_cnt_d = '0;
                    fb_cnt_d  = '0;
                    good_d    = '0;
                end
                MEASURE, LOCKED: begin
                    if (win_q == WIN_LAST) begin
                        win_d       = '0;
                        ref_cnt_d   = '0;
                        fb_cnt_d    = '0;
                        done_d      = 1'b1;
                        ref_count_d = ref_inc;
                        fb_count_d  = fb_inc;
                        ref_lost_d  = (ref_inc == '0);
                        fb_lost_d   = (fb_inc == '0);
                        if (ref_ok && fb_ok) begin
                            if (state_q == MEASURE) begin
                                good_d = good_inc;
                                if (good_inc == 4'(LOCK_WINDOWS)) begin
                                    state_d = LOCKED;
                                    lock_d  = 1'b1;
                                end
                            end
                        end else begin
                            state_d = MEASURE;
                            good_d  = '0;
                            lock_d  = 1'b0;
                        end
                    end else begin
                        win_d     = win_q + WIN_W'(1);
                        ref_cnt_d = ref_inc;
                        fb_cnt_d  = fb_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge lockdet_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= '0;
            ref_cnt_q   <= '0;
            fb_cnt_q    <= '0;
            good_q      <= '0;
            lock_q      <= 1'b0;
            ref_lost_q  <= 1'b0;
            fb_lost_q   <= 1'b0;
            ref_count_q <= '0;
            fb_count_q  <= '0;
            done_q      <= 1'b0;
            ref_sync_q  <= '0;
            fb_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            ref_cnt_q   <= ref_cnt_d;
            fb_cnt_q    <= fb_cnt_d;
            good_q      <= good_d;
            lock_q      <= lock_d;
            ref_lost_q  <= ref_lost_d;
            fb_lost_q   <= fb_lost_d;
            ref_count_q <= ref_count_d;
            fb_count_q  <= fb_count_d;
            done_q      <= done_d;
            ref_sync_q  <= ref_sync_d;
            fb_sync_q   <= fb_sync_d;
        end
    end

    assign bus.CPLLLOCK       = lock_q;
    assign bus.CPLLREFCLKLOST = ref_lost_q;
    assign bus.CPLLFBCLKLOST  = fb_lost_q;
    assign bus.ref_count      = ref_count_q;
    assign bus.fb_count       = fb_count_q;
    assign bus.window_done    = done_q;

endmodule

// File: tb/tb_gtxe2_chnl_cpll_lockdet.sv
// ----------------------------------------------------------------------------
// tb_gtxe2_chnl_cpll_lockdet
//
// Main instance: WINDOW=64, REF_EXP=16, FB_EXP=32, TOL=1, LOCK_WINDOWS=4.
// Saturation instance: same but CNT_W=4, both inputs toggling every cycle.
// Observed clocks change 3 time units after each lockdet_clk rising edge;
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_gtxe2_chnl_cpll_lockdet;

    logic lockdet_clk = 1'b0;
    logic rst_n;
    always #5 lockdet_clk = ~lockdet_clk;

    gtxe2_chnl_cpll_lockdet_if #(.CNT_W(16)) m_if ();
    gtxe2_chnl_cpll_lockdet_if #(.CNT_W(4))  s_if ();

    gtxe2_chnl_cpll_lockdet #(
        .WINDOW(64), .REF_EXP(16), .FB_EXP(32), .TOL(1),
        .LOCK_WINDOWS(4), .CNT_W(16)
    ) dut (
        .lockdet_clk (lockdet_clk),
        .rst_n       (rst_n),
        .bus         (m_if.slave)
    );

    gtxe2_chnl_cpll_lockdet #(
        .WINDOW(64), .REF_EXP(16), .FB_EXP(32), .TOL(1),
        .LOCK_WINDOWS(4), .CNT_W(4)
    ) dut_sat (
        .lockdet_clk (lockdet_clk),
        .rst_n       (rst_n),
        .bus         (s_if.slave)
    );

    // Observed clock generation
    logic fb_run  = 1'b1;
    logic ref_run = 1'b1;
    int   ref_per = 4;
    int   ref_ph  = 0;
    logic fb_tb   = 1'b0;
    logic ref_tb  = 1'b0;
    logic sat_tb  = 1'b0;

    always @(posedge lockdet_clk) begin
        #3;
        if (fb_run) fb_tb = ~fb_tb;
        else        fb_tb = 1'b0;
        if (ref_run) begin
            ref_tb = (ref_ph < ref_per / 2);
            ref_ph = (ref_ph + 1) % ref_per;
        end else begin
            ref_tb = 1'b0;
            ref_ph = 0;
        end
        sat_tb = ~sat_tb;
    end

    assign m_if.ref_clk = ref_tb;
    assign m_if.fb_clk  = fb_tb;
    assign s_if.ref_clk = sat_tb;
    assign s_if.fb_clk  = sat_tb;
    assign s_if.lock_en = 1'b1;
    assign s_if.pd      = 1'b0;

    int n_checks    = 0;
    int n_fail      = 0;
    int sat_windows = 0;

    typedef struct {
        bit fb_run;
        bit ref_run;
        int gap;        // falling edges from previous update to this one
        int ref_lo;
        int ref_hi;
        int fb_lo;
        int fb_hi;
        bit lock;
        bit chk_lost;   // lost flags expected as (hi == 0)
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [31:0] act,
                             input int lo, input int hi);
        n_checks++;
        if ($isunknown(act) || (int'(act) < lo) || (int'(act) > hi)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One detector cycle; also scores the saturation instance when it updates.
    task automatic tick();
        @(negedge lockdet_clk);
        if (rst_n && s_if.window_done) begin
            check("sat_fb_count", 32'(s_if.fb_count), 15);
            check("sat_ref_count", 32'(s_if.ref_count), 15);
            check("sat_lock", 32'(s_if.CPLLLOCK), 0);
            sat_windows++;
        end
    endtask

    task automatic wait_window(output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (m_if.window_done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL window_timeout: got no window_done, expected one within 200 cycles");
        end
    endtask

    task automatic check_window(input string tag, input vec_t v);
        int cyc;
        wait_window(cyc);
        check({tag, " gap"}, 32'(cyc), 32'(v.gap));
        check_rng({tag, " ref_count"}, 32'(m_if.ref_count), v.ref_lo, v.ref_hi);
        check_rng({tag, " fb_count"}, 32'(m_if.fb_count), v.fb_lo, v.fb_hi);
        check({tag, " lock"}, 32'(m_if.CPLLLOCK), 32'(v.lock));
        if (v.chk_lost) begin
            check({tag, " ref_lost"}, 32'(m_if.CPLLREFCLKLOST), 32'(v.ref_hi == 0));
            check({tag, " fb_lost"}, 32'(m_if.CPLLFBCLKLOST), 32'(v.fb_hi == 0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " lock"}, 32'(m_if.CPLLLOCK), 0);
        check({tag, " ref_lost"}, 32'(m_if.CPLLREFCLKLOST), 0);
        check({tag, " fb_lost"}, 32'(m_if.CPLLFBCLKLOST), 0);
        check({tag, " ref_count"}, 32'(m_if.ref_count), 0);
        check({tag, " fb_count"}, 32'(m_if.fb_count), 0);
        check({tag, " window_done"}, 32'(m_if.window_done), 0);
    endtask

    // Four windows after an enable: lock only on the fourth.
    task automatic relock(input string tag);
        vec_t v;
        for (int w = 0; w < 4; w++) begin
            v = '{1'b1, 1'b1, (w == 0) ? 65 : 64, 16, 16, 32, 32, (w == 3), 1'b1};
            check_window($sformatf("%s w%0d", tag, w), v);
        end
    endtask

    initial begin
        int   dones;
        vec_t v5;
        //            fb  ref gap  rlo rhi flo fhi lock lost
        tbl[0]  = '{1'b1, 1'b1, 65, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 64, 16, 16,  1,  2, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 64, 16, 16,  0,  0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 64, 16, 16, 31, 31, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 64,  0,  1, 32, 32, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 64,  0,  0, 32, 32, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 64, 16, 16, 32, 32, 1'b1, 1'b1};

        rst_n        = 1'b0;
        m_if.lock_en = 1'b0;
        m_if.pd      = 1'b0;
        repeat (3) tick();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        repeat (10) tick();
        check_all_zero("idle_disabled");

        // Lock, fb_clk loss/recovery, ref_clk loss/recovery
        m_if.lock_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            fb_run  = tbl[i].fb_run;
            ref_run = tbl[i].ref_run;
            check_window($sformatf("row%0d", i), tbl[i]);
        end

        // One-cycle lock_en drop while locked
        repeat (10) tick();
        m_if.lock_en = 1'b0;
        tick();
        check_all_zero("lock_en_drop");
        m_if.lock_en = 1'b1;
        relock("after_lock_en");

        // Asynchronous reset mid-window while locked
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_if.lock_en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_all_zero("post_reset_idle");
        m_if.lock_en = 1'b1;
        relock("after_reset");

        // ref_clk period 5: off-frequency, never locks
        m_if.lock_en = 1'b0;
        ref_per      = 5;
        repeat (10) tick();
        check("per5_idle_lock", 32'(m_if.CPLLLOCK), 0);
        m_if.lock_en = 1'b1;
        for (int w = 0; w < 6; w++) begin
            v5 = '{1'b1, 1'b1, (w == 0) ? 65 : 64, 12, 13, 32, 32, 1'b0, 1'b1};
            check_window($sformatf("per5 w%0d", w), v5);
        end

        // Power-down mid-window clears outputs and stops updates
        repeat (10) tick();
        m_if.pd = 1'b1;
        tick();
        check_all_zero("pd_assert");
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (m_if.window_done) dones++;
        end
        check("pd_no_window_done", 32'(dones), 0);

        check("sat_windows_seen", 32'(sat_windows > 5), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
